// File: rtl/vga_fb_pkg.sv
// Shared constants, FSM encoding and cell-address helper for the VGA frame-buffer renderer.
package vga_fb_pkg;

  localparam logic [7:0]  FB_W       = 8'd160;   // frame buffer width in cells
  localparam logic [6:0]  FB_H       = 7'd120;   // frame buffer height in cells
  localparam int          FB_DEPTH   = 19200;    // cells per bank
  localparam int          FB_AW      = 15;       // cell address width
  localparam int          SCALE_LOG2 = 2;        // 4x4 screen pixels per cell
  localparam logic [11:0] BG_COLOR   = 12'h000;  // bbbb_gggg_rrrr outside the picture

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FILL      = 2'd1,
    WAIT_SWAP = 2'd2
  } fb_state_e;

  // y*160 + x, built from shifts so no multiplier is needed.
  function automatic logic [FB_AW-1:0] cell_addr(input logic [6:0] y, input logic [7:0] x);
    logic [FB_AW-1:0] yy;
    yy = {8'd0, y};
    return (yy << 7) + (yy << 5) + {7'd0, x};
  endfunction

endpackage

// File: rtl/vga_fb_renderer_if.sv
// Bundles the pixel read port and the game-logic command/swap port of the renderer.
interface vga_fb_renderer_if;

  // pixel read side (sync generator)
  logic [8:0]  row_addr;
  logic [9:0]  col_addr;
  logic        rdn;
  logic        vs;
  logic [11:0] d_out;

  // command side (game logic)
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_clear;
  logic [7:0]  cmd_x0;
  logic [6:0]  cmd_y0;
  logic [7:0]  cmd_w;
  logic [6:0]  cmd_h;
  logic [11:0] cmd_color;
  logic        cmd_done;
  logic        swap_req;
  logic        swap_done;
  logic        front_sel;

  modport master (
    output row_addr, col_addr, rdn, vs,
    output cmd_valid, cmd_clear, cmd_x0, cmd_y0, cmd_w, cmd_h, cmd_color, swap_req,
    input  d_out, cmd_ready, cmd_done, swap_done, front_sel
  );

  modport slave (
    input  row_addr, col_addr, rdn, vs,
    input  cmd_valid, cmd_clear, cmd_x0, cmd_y0, cmd_w, cmd_h, cmd_color, swap_req,
    output d_out, cmd_ready, cmd_done, swap_done, front_sel
  );

endinterface

// File: rtl/fb_bank_ram.sv
// One frame-buffer bank: 19200 x 12 simple dual-port RAM, one write port, one registered read port.
module fb_bank_ram
  import vga_fb_pkg::*;
(
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [FB_AW-1:0] waddr_i,
  input  logic [11:0]      wdata_i,
  input  logic [FB_AW-1:0] raddr_i,
  output logic [11:0]      rdata_o
);

  logic [11:0] mem_q [FB_DEPTH];
  logic [11:0] rdata_q;

  // write port: one cell per cycle from the fill engine
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // synchronous read port for the display
  always_ff @(posedge clk_i) begin
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/vga_fb_renderer.sv
// Double-buffered 160x120 frame buffer: serves display reads from the front bank,
// renders rectangle/clear commands into the back bank, swaps banks on vsync.
module vga_fb_renderer
  import vga_fb_pkg::*;
(
  input  logic               vga_clk,
  input  logic               clrn,
  vga_fb_renderer_if.slave   bus
);

  // ---------------- read path ----------------
  logic [6:0]       rd_y;
  logic [7:0]       rd_x;
  logic             rd_in_range;
  logic [FB_AW-1:0] rd_addr;
  logic [11:0]      rdata0, rdata1;
  logic             bg_q, bg_d;
  logic             rd_bank_q;

  assign rd_y        = bus.row_addr[8:SCALE_LOG2];
  assign rd_x        = bus.col_addr[9:SCALE_LOG2];
  assign rd_in_range = (rd_y < FB_H) && (rd_x < FB_W);
  // Out-of-range cells are masked anyway; parking the address keeps the RAM index legal.
  assign rd_addr     = rd_in_range ? cell_addr(rd_y, rd_x) : '0;
  assign bg_d        = bus.rdn | ~rd_in_range;

  // capture blanking decision and bank for the read issued this cycle
  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      bg_q      <= 1'b1;
      rd_bank_q <= 1'b0;
    end else begin
      bg_q      <= bg_d;
      rd_bank_q <= bus.front_sel;
    end
  end

  assign bus.d_out = bg_q ? BG_COLOR : (rd_bank_q ? rdata1 : rdata0);

  // ---------------- command engine ----------------
  fb_state_e   state_q, state_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        cmd_done_q, cmd_done_d;
  logic        swap_done_q, swap_done_d;
  logic        front_sel_q, front_sel_d;
  logic        swap_pend_q, swap_pend_d;
  logic        vs_q;

  logic [7:0]  x_q, x_d;
  logic [6:0]  y_q, y_d;
  logic [7:0]  x0_q, x0_d;
  logic [7:0]  xe_q, xe_d;
  logic [6:0]  ye_q, ye_d;
  logic [11:0] color_q, color_d;

  // Clipping: sums are one bit wider than the operands so they never wrap.
  logic [8:0]  x_sum;
  logic [7:0]  y_sum;
  logic [7:0]  x_clip;
  logic [6:0]  y_clip;
  logic        degen;
  logic        vs_fall;

  assign x_sum   = {1'b0, bus.cmd_x0} + {1'b0, bus.cmd_w};
  assign y_sum   = {1'b0, bus.cmd_y0} + {1'b0, bus.cmd_h};
  assign x_clip  = (x_sum >= {1'b0, FB_W}) ? (FB_W - 8'd1) : (x_sum[7:0] - 8'd1);
  assign y_clip  = (y_sum >= {1'b0, FB_H}) ? (FB_H - 7'd1) : (y_sum[6:0] - 7'd1);
  assign degen   = (bus.cmd_x0 >= FB_W) || (bus.cmd_y0 >= FB_H) ||
                   (bus.cmd_w == 8'd0) || (bus.cmd_h == 7'd0);
  assign vs_fall = vs_q & ~bus.vs;

  // next-state and command/swap sequencing
  always_comb begin
    state_d     = state_q;
    cmd_done_d  = 1'b0;
    swap_done_d = 1'b0;
    front_sel_d = front_sel_q;
    swap_pend_d = swap_pend_q | bus.swap_req;
    x_d         = x_q;
    y_d         = y_q;
    x0_d        = x0_q;
    xe_d        = xe_q;
    ye_d        = ye_q;
    color_d     = color_q;

    case (state_q)
      IDLE: begin
        if (swap_pend_q || bus.swap_req) begin
          state_d = WAIT_SWAP;
        end else if (bus.cmd_valid && cmd_ready_q) begin
          if (bus.cmd_clear) begin
            x0_d    = 8'd0;
            x_d     = 8'd0;
            y_d     = 7'd0;
            xe_d    = FB_W - 8'd1;
            ye_d    = FB_H - 7'd1;
            color_d = bus.cmd_color;
            state_d = FILL;
          end else if (degen) begin
            cmd_done_d = 1'b1;
          end else begin
            x0_d    = bus.cmd_x0;
            x_d     = bus.cmd_x0;
            y_d     = bus.cmd_y0;
            xe_d    = x_clip;
            ye_d    = y_clip;
            color_d = bus.cmd_color;
            state_d = FILL;
          end
        end
      end
      FILL: begin
        if (x_q == xe_q) begin
          x_d = x0_q;
          if (y_q == ye_q) begin
            cmd_done_d = 1'b1;
            // A swap requested during the fill goes straight to waiting for vsync,
            // so no new command can slip in between.
            state_d    = swap_pend_d ? WAIT_SWAP : IDLE;
          end else begin
            y_d = y_q + 7'd1;
          end
        end else begin
          x_d = x_q + 8'd1;
        end
      end
      WAIT_SWAP: begin
        if (vs_fall) begin
          front_sel_d = ~front_sel_q;
          swap_done_d = 1'b1;
          swap_pend_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    cmd_ready_d = (state_d == IDLE);
  end

  // control registers
  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      cmd_done_q  <= 1'b0;
      swap_done_q <= 1'b0;
      front_sel_q <= 1'b0;
      swap_pend_q <= 1'b0;
      vs_q        <= 1'b1;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      cmd_done_q  <= cmd_done_d;
      swap_done_q <= swap_done_d;
      front_sel_q <= front_sel_d;
      swap_pend_q <= swap_pend_d;
      vs_q        <= bus.vs;
    end
  end

  // fill coordinates and colour (datapath, no reset needed)
  always_ff @(posedge vga_clk) begin
    x_q     <= x_d;
    y_q     <= y_d;
    x0_q    <= x0_d;
    xe_q    <= xe_d;
    ye_q    <= ye_d;
    color_q <= color_d;
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.cmd_done  = cmd_done_q;
  assign bus.swap_done = swap_done_q;
  assign bus.front_sel = front_sel_q;

  // ---------------- banks ----------------
  logic             wr_en;
  logic [FB_AW-1:0] wr_addr;
  logic             we0, we1;

  assign wr_en   = (state_q == FILL);
  assign wr_addr = cell_addr(y_q, x_q);
  // Writes always target the back bank (the one not displayed).
  assign we0     = wr_en &  front_sel_q;
  assign we1     = wr_en & ~front_sel_q;

  fb_bank_ram u_bank0 (
    .clk_i   (vga_clk),
    .we_i    (we0),
    .waddr_i (wr_addr),
    .wdata_i (color_q),
    .raddr_i (rd_addr),
    .rdata_o (rdata0)
  );

  fb_bank_ram u_bank1 (
    .clk_i   (vga_clk),
    .we_i    (we1),
    .waddr_i (wr_addr),
    .wdata_i (color_q),
    .raddr_i (rd_addr),
    .rdata_o (rdata1)
  );

endmodule

// File: doc/vga_fb_renderer.md
Name: vga_fb_renderer

Overview:
- Pixel-RAM responder behind the VGA sync generator: serves 12-bit bbbb_gggg_rrrr pixels for the generator's row/col read requests.
- Accepts rectangle-fill and clear commands from game logic, and renders them into a double-buffered 160x120 frame buffer (4x4 pixel upscaling to 640x480).
- Swaps front/back banks only during vertical sync, so the display never tears.

Parameters:
FB_W, 160, frame buffer width in cells
FB_H, 120, frame buffer height in cells
SCALE_LOG2, 2, log2 of screen pixels per cell edge
BG_COLOR, 12'h000, pixel returned outside the active area or out of range

Ports:
vga_clk  in  1  25 MHz pixel clock, shared with the sync generator
clrn  in  1  asynchronous active-low reset
row_addr  in  9  display row, 0..479
col_addr  in  10  display column, 0..639
rdn  in  1  active-low read strobe from the sync generator
vs  in  1  vertical sync from the sync generator; low during the sync pulse
d_out  out  12  pixel data, bbbb_gggg_rrrr
cmd_valid  in  1  fill command present
cmd_ready  out  1  engine able to accept a command
cmd_clear  in  1  ignore coordinates; fill the whole back bank
cmd_x0  in  8  left cell column
cmd_y0  in  7  top cell row
cmd_w  in  8  width in cells
cmd_h  in  7  height in cells
cmd_color  in  12  fill colour
cmd_done  out  1  one-cycle pulse when a command completes
swap_req  in  1  one-cycle pulse requesting a bank swap
swap_done  out  1  one-cycle pulse when the swap takes effect
front_sel  out  1  index of the bank currently displayed

Behaviour:
- Reset (async, clrn low): d_out=BG_COLOR, cmd_ready=0, cmd_done=0, swap_done=0, front_sel=0, FSM=IDLE, swap_pend=0, vs_q=1.
  - RAM contents are not reset.
  - cmd_ready rises in the first cycle after clrn deasserts.
- Read port (front bank):
  - Cell address = row_addr[8:2]*160 + col_addr[9:2], 15 bits; compute the multiply as (y<<7)+(y<<5)+x.
  - d_out is registered and valid exactly 1 vga_clk after the address and rdn are presented.
  - d_out = BG_COLOR when rdn=1, or when the cell row >= FB_H, or when the cell column >= FB_W.
- Write port (back bank = ~front_sel): one cell written per cycle.
- FSM states: IDLE, FILL, WAIT_SWAP.
- IDLE:
  - cmd_ready=1.
  - If swap_pend=1 or swap_req=1, go to WAIT_SWAP. This takes priority over a simultaneous cmd_valid; that command is not accepted.
  - Otherwise, on cmd_valid&cmd_ready, latch the command and clip it:
    - cmd_clear: x0=0, y0=0, x_end=159, y_end=119.
    - Else x_end = min(x0+w, 160)-1 and y_end = min(y0+h, 120)-1; compute the sums at 9/8 bits so they cannot wrap.
    - Degenerate (x0>=160, y0>=120, w=0 or h=0): no writes; cmd_done pulses the next cycle; stay in IDLE.
    - Non-degenerate: go to FILL.
- FILL:
  - cmd_ready=0.
  - Write order is row-major: x increments each cycle; at x_end, x returns to x0 and y increments.
  - After writing (x_end, y_end), pulse cmd_done in the next cycle and go to IDLE.
  - Write count = (x_end-x0+1)*(y_end-y0+1) cycles.
  - A swap_req during FILL sets swap_pend; it is serviced after the fill completes.
- WAIT_SWAP:
  - cmd_ready=0.
  - vs_q is a registered copy of vs. On a falling edge of vs (vs_q=1 and vs=0), toggle front_sel, pulse swap_done, clear swap_pend and go to IDLE.
  - Extra swap_req pulses while a swap is pending merge into that single pending swap.
- Read/write collision cannot occur, because reads use the front bank and writes use the back bank; front_sel never changes mid-FILL.
- Reset mid-FILL aborts the fill; partially written cells remain in RAM; no cmd_done is issued.

Decomposition:
- Package vga_fb_pkg holds:
  - constants FB_W, FB_H, FB_DEPTH=19200, FB_AW=15, BG_COLOR;
  - the FSM state encoding (IDLE, FILL, WAIT_SWAP);
  - the cell-address function y*160+x.
- One sub-module, fb_bank_ram: simple dual-port 19200x12 RAM, one write port and one synchronous-read port; instantiated twice.
  - Bank select muxes live in the parent.

Test Plan:
- Reset, then read cell (0,0) with rdn=0 -> d_out=BG_COLOR; cmd_ready=1 in the first cycle after reset release; front_sel=0.
- Fill x0=10, y0=5, w=3, h=2, colour 12'h0F0, then swap_req -> cmd_done exactly 6 cycles after FILL entry; swap_done on the next vs falling edge; front_sel=1; row_addr=20, col_addr=40 reads 12'h0F0 one cycle later; col_addr=52 reads BG_COLOR.
- Fill x0=158, y0=119, w=10, h=10 -> only cells (158,119) and (159,119) are written; cmd_done after 2 write cycles; cell (0,0) of the next row is unchanged.
- w=0, and separately x0=200 -> no RAM writes; cmd_done 1 cycle after acceptance; cmd_ready returns to 1.
- swap_req during a cmd_clear FILL -> cmd_ready stays 0 through all 19200 write cycles and then until the first vs falling edge; swap_done fires exactly once; no tearing, since no front-bank write is observed during the fill.
- rdn=1 with valid addresses, and col_addr=639/row_addr=479 with rdn=0 -> d_out=BG_COLOR when rdn=1; cell (159,119) contents at the corner; pulse clrn mid-FILL -> all outputs at reset values immediately.
